// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder: data-memory responder for the M stage.
// Accepts one load/store at a time over a req/addr_ok/data_ok handshake,
// waits WAIT_CYCLES wait states, then performs a word access with byte-lane
// write strobes. busy stalls the pipeline while a transaction is in flight.
module dmem_sram_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [31:0]       r_rdata;

   // Request captured at accept; only meaningful while a transaction is open.
   logic              r_wr;
   logic [3:0]        r_wstrb;
   logic [31:0]       r_wdata;
   logic [ADDR_W-1:0] r_idx;

   logic [31:0]       r_mem [2**ADDR_W];

   logic              w_idle;
   logic              w_accept;
   logic              w_access;
   logic              w_unused;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_idle & req;
   assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

   // Byte offset and bits above the array size are dropped (addresses alias).
   assign w_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

   assign addr_ok = w_idle;
   assign data_ok = (r_state == S_DONE);
   assign busy    = w_accept | (r_state == S_WAIT);
   assign rdata   = r_rdata;

   // Control FSM: accept in IDLE, count down wait states, pulse DONE, load rdata.
   always_ff @(posedge clka) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_cnt   <= WAIT_INIT;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (!r_wr) begin
                     r_rdata <= r_mem[r_idx];
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Capture the request fields in the accept cycle only.
   always_ff @(posedge clka) begin
      if (w_accept) begin
         r_wr    <= wr;
         r_wstrb <= wstrb;
         r_wdata <= wdata;
         r_idx   <= addr[ADDR_W+1:2];
      end
   end

   // Byte-lane store; reset on the access edge cancels the commit.
   always_ff @(posedge clka) begin
      // NOTE: the array is deliberately not reset so it maps onto SRAM/BRAM;
      // only control state is cleared.
      if (!rst && w_access && r_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) begin
               r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Self-checking bench for dmem_sram_responder: directed scenarios plus a
// randomized load/store mix against a word-array reference model.
module tb_dmem_sram_responder;

   localparam int ADDR_W      = 10;
   localparam int WAIT_CYCLES = 2;

   logic        clka = 1'b0;
   logic        rst;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: word index -> contents, and the last completed load.
   logic [31:0] model_mem [int];
   logic [31:0] model_rdata;

   dmem_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clka    (clka),
      .rst     (rst),
      .req     (req),
      .wr      (wr),
      .wstrb   (wstrb),
      .addr    (addr),
      .wdata   (wdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok),
      .rdata   (rdata),
      .busy    (busy)
   );

   always #5 clka = ~clka;

   // Advance one cycle; inputs are driven at +2, outputs sampled at +3.
   task automatic tick;
      @(posedge clka);
      #2;
   endtask

   function automatic int word_of(input logic [31:0] a);
      logic [31:0] span;
      span = 32'd1 << (ADDR_W + 2);
      return int'((a % span) / 4);
   endfunction

   // One complete transaction starting from an IDLE cycle; returns rdata at data_ok.
   task automatic do_txn(input bit t_wr, input logic [3:0] t_strb,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input string name, output logic [31:0] got);
      int lat;
      int busy_after;
      int bad_aok;
      bit done;
      logic busy_done;
      logic [31:0] old;
      req = 1'b1; wr = t_wr; wstrb = t_strb; addr = t_addr; wdata = t_wdata;
      #1;
      n_cmp++;
      if (addr_ok !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL %s accept: addr_ok=%b busy=%b, required 1 1", name, addr_ok, busy);
      end
      lat = 0; busy_after = 0; bad_aok = 0; done = 1'b0; busy_done = 1'bx;
      while (!done && lat < 40) begin
         tick();
         lat++;
         // Scramble inputs after accept: they must not affect this transaction.
         req = 1'b0; wr = 1'($urandom); wstrb = 4'($urandom);
         addr = $urandom; wdata = $urandom;
         #1;
         if (addr_ok !== 1'b0) bad_aok++;
         if (data_ok === 1'b1) begin
            done = 1'b1;
            busy_done = busy;
         end else if (busy === 1'b1) begin
            busy_after++;
         end
      end
      got = rdata;
      n_cmp++;
      if (lat != WAIT_CYCLES + 2 || !done) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles (done=%0b), required %0d", name, lat, done, WAIT_CYCLES + 2);
      end
      n_cmp++;
      if (busy_after != WAIT_CYCLES + 1 || busy_done !== 1'b0) begin
         n_err++;
         $display("FAIL %s busy: %0d cycles after accept, busy in DONE=%b, required %0d and 0",
                  name, busy_after, busy_done, WAIT_CYCLES + 1);
      end
      n_cmp++;
      if (bad_aok != 0) begin
         n_err++;
         $display("FAIL %s addr_ok: high in %0d busy/done cycles, required 0", name, bad_aok);
      end
      if (t_wr) begin
         old = model_mem.exists(word_of(t_addr)) ? model_mem[word_of(t_addr)] : 32'd0;
         for (int i = 0; i < 4; i++)
            if (t_strb[i]) old[8*i +: 8] = t_wdata[8*i +: 8];
         model_mem[word_of(t_addr)] = old;
      end else begin
         model_rdata = model_mem[word_of(t_addr)];
      end
      n_cmp++;
      if (got !== model_rdata) begin
         n_err++;
         $display("FAIL %s rdata: got %h, required %h", name, got, model_rdata);
      end
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; addr = 32'd0; wdata = 32'd0;
      repeat (3) tick();
      rst = 1'b0;
      model_rdata = 32'd0;
      #1;
      n_cmp++;
      if (addr_ok !== 1'b1 || busy !== 1'b0 || data_ok !== 1'b0 || rdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset: addr_ok=%b busy=%b data_ok=%b rdata=%h, required 1 0 0 00000000",
                  addr_ok, busy, data_ok, rdata);
      end
      req = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b1 || addr_ok !== 1'b1) begin
         n_err++;
         $display("FAIL reset_busy_eq_req: busy=%b addr_ok=%b, required 1 1", busy, addr_ok);
      end
      req = 1'b0;
      tick();
   endtask

   task automatic test_store_load;
      logic [31:0] got;
      do_txn(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, "store_0x40", got);
      do_txn(1'b0, 4'h0, 32'h40, 32'h0, "load_0x40", got);
      n_cmp++;
      if (got !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL store_load value: got %h, required deadbeef", got);
      end
   endtask

   task automatic test_partial_write;
      logic [31:0] got;
      do_txn(1'b1, 4'hF, 32'h80, 32'h11223344, "pw_full", got);
      do_txn(1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, "pw_partial", got);
      do_txn(1'b0, 4'h0, 32'h80, 32'h0, "pw_load1", got);
      n_cmp++;
      if (got !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL partial_write: got %h, required 11bb33dd", got);
      end
      do_txn(1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, "pw_nostrb", got);
      do_txn(1'b0, 4'h0, 32'h80, 32'h0, "pw_load2", got);
      n_cmp++;
      if (got !== 32'h11BB33DD) begin
         n_err++;
         $display("FAIL zero_strobe_store: got %h, required 11bb33dd", got);
      end
   endtask

   task automatic test_alias;
      logic [31:0] got;
      do_txn(1'b1, 4'hF, 32'h0000_1004, 32'h12345678, "alias_store", got);
      do_txn(1'b0, 4'h0, 32'h0000_0004, 32'h0, "alias_load4", got);
      n_cmp++;
      if (got !== 32'h12345678) begin
         n_err++;
         $display("FAIL alias_0x4: got %h, required 12345678", got);
      end
      do_txn(1'b0, 4'h0, 32'h0000_0007, 32'h0, "alias_load7", got);
      n_cmp++;
      if (got !== 32'h12345678) begin
         n_err++;
         $display("FAIL alias_0x7: got %h, required 12345678", got);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] got;
      logic [31:0] la [3];
      logic [31:0] q [$];
      logic [31:0] exp_d;
      int cyc, n_acc, last_acc;
      bit acc_now;
      for (int i = 0; i < 3; i++) begin
         la[i] = 32'h200 + 32'(4 * i);
         do_txn(1'b1, 4'hF, la[i], $urandom, "b2b_preload", got);
      end
      cyc = 0; n_acc = 0; last_acc = -1;
      req = 1'b1; wr = 1'b0; wstrb = 4'h0; addr = la[0];
      #1;
      while (cyc < 60 && !(n_acc == 3 && q.size() == 0)) begin
         acc_now = 1'b0;
         if (addr_ok === 1'b1 && req === 1'b1) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (cyc - last_acc != WAIT_CYCLES + 3) begin
                  n_err++;
                  $display("FAIL b2b_spacing: %0d cycles, required %0d", cyc - last_acc, WAIT_CYCLES + 3);
               end
            end
            last_acc = cyc;
            q.push_back(model_mem[word_of(addr)]);
            n_acc++;
            acc_now = 1'b1;
         end
         if (data_ok === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL b2b_data_ok: unexpected data_ok, rdata=%h, required no pulse", rdata);
            end else begin
               exp_d = q.pop_front();
               model_rdata = exp_d;
               if (rdata !== exp_d) begin
                  n_err++;
                  $display("FAIL b2b_rdata: got %h, required %h", rdata, exp_d);
               end
            end
         end
         tick();
         cyc++;
         if (acc_now) begin
            if (n_acc < 3) addr = la[n_acc];
            else req = 1'b0;
         end
         #1;
      end
      n_cmp++;
      if (n_acc != 3 || q.size() != 0) begin
         n_err++;
         $display("FAIL b2b_count: %0d accepts, %0d outstanding, required 3 and 0", n_acc, q.size());
      end
   endtask

   // Store accepted at T, rst asserted during cycle T+k; nothing may commit.
   task automatic reset_during(input int k, input logic [31:0] d, input string name);
      logic [31:0] got;
      int n_dok;
      do_txn(1'b1, 4'hF, 32'h10, 32'h0, "rst_clear", got);
      n_dok = 0;
      req = 1'b1; wr = 1'b1; wstrb = 4'hF; addr = 32'h10; wdata = d;
      #1;
      for (int c = 1; c <= k + 6; c++) begin
         tick();
         req = 1'b0;
         rst = (c == k);
         #1;
         if (data_ok === 1'b1) n_dok++;
      end
      model_rdata = 32'd0;
      n_cmp++;
      if (n_dok != 0 || rdata !== 32'd0) begin
         n_err++;
         $display("FAIL %s abandon: data_ok pulses=%0d rdata=%h, required 0 00000000", name, n_dok, rdata);
      end
      tick();
      do_txn(1'b0, 4'h0, 32'h10, 32'h0, name, got);
      n_cmp++;
      if (got !== 32'h0) begin
         n_err++;
         $display("FAIL %s commit: got %h, required 00000000", name, got);
      end
   endtask

   task automatic test_reset_mid_store;
      reset_during(2, 32'hCAFEF00D, "rst_wait");
      reset_during(WAIT_CYCLES + 1, 32'hFFFFFFFF, "rst_access_edge");
   endtask

   task automatic test_random;
      logic [31:0] got;
      int idx [8];
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         idx[i] = int'($urandom_range(0, (1 << ADDR_W) - 1));
         do_txn(1'b1, 4'hF, 32'(idx[i] * 4), $urandom, "rnd_init", got);
      end
      for (int n = 0; n < 60; n++) begin
         a = ($urandom & ~((32'd1 << (ADDR_W + 2)) - 1))
             | 32'(idx[$urandom_range(0, 7)] * 4) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            do_txn(1'b1, 4'($urandom), a, $urandom, "rnd_store", got);
         else
            do_txn(1'b0, 4'($urandom), a, $urandom, "rnd_load", got);
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial_write();
      test_alias();
      test_back_to_back();
      test_reset_mid_store();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
